// File: rtl/ret_addr_stack_pkg.sv
// Shared width defines and common types for the return-address stack.
// Optional build macro: RAS_OVERFLOW_WRAP_EN (circular overwrite on push-when-full).
`ifndef RET_ADDR_STACK_DEFINES
`define RET_ADDR_STACK_DEFINES
`define DATAWIDTH 16
`define RASDEPTH 8
`define RASPTRW 3
`endif

package ret_addr_stack_pkg;

  localparam int unsigned DATA_W  = `DATAWIDTH;
  localparam int unsigned DEPTH   = `RASDEPTH;
  localparam int unsigned PTR_W   = `RASPTRW;
  localparam int unsigned COUNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RAS_OP_NONE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_REPLACE
  } ras_op_e;

  // Push+pop on an empty stack degenerates to a plain push.
  function automatic ras_op_e ras_decode(input logic push, input logic pop, input logic empty);
    ras_op_e op;
    op = RAS_OP_NONE;
    if (push && pop && !empty) begin
      op = RAS_OP_REPLACE;
    end else if (push) begin
      op = RAS_OP_PUSH;
    end else if (pop) begin
      op = RAS_OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/ret_addr_stack_regfile.sv
// Return-address storage: one write port, one asynchronous read port, no reset.
module ras_regfile
  import ret_addr_stack_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Hardware return-address stack: push on call, pop on return, sticky over/underflow.
// Build macro RAS_OVERFLOW_WRAP_EN: push when full overwrites the oldest entry.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] ra_in,
  output logic [DATA_W-1:0] ra_top,
  output logic              ra_valid,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  logic [PTR_W-1:0]   sp_q, sp_d, sp_m1;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic               we;
  logic [PTR_W-1:0]   waddr;
  logic [DATA_W-1:0]  rdata;
  logic               empty;
  ras_op_e            op;

  // Pointer arithmetic relies on DEPTH being 2**PTR_W so that sp wraps naturally.
  assign sp_m1 = sp_q - PTR_W'(1);
  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_W'(DEPTH));
  assign op    = en ? ras_decode(push, pop, empty) : RAS_OP_NONE;

  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = sp_q;

    unique case (op)
      RAS_OP_REPLACE: begin
        we    = 1'b1;
        waddr = sp_m1;
      end
      RAS_OP_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          sp_d    = sp_q + PTR_W'(1);
          count_d = count_q + COUNT_W'(1);
        end else begin
          overflow_d = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
          we   = 1'b1;
          sp_d = sp_q + PTR_W'(1);
`endif
        end
      end
      RAS_OP_POP: begin
        if (!empty) begin
          sp_d    = sp_m1;
          count_d = count_q - COUNT_W'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
      RAS_OP_NONE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  ras_regfile u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (ra_in),
    .raddr (sp_m1),
    .rdata (rdata)
  );

  assign ra_top    = empty ? '0 : rdata;
  assign ra_valid  = !empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
